// File: rtl/bus_cycle_sequencer_if.sv
// Bundle of execute-unit request, pin inputs and sequencer strobes for bus_cycle_sequencer.
// The master modport is the sequencer itself; the slave modport is its environment.
interface bus_cycle_sequencer_if;
  logic       cyc_req;
  logic [2:0] cyc_type;
  logic       cyc_last;
  logic       mwait;
  logic       busrq;
  logic       intr;
  logic       nmi;
  logic       iff1;
  logic       cyc_ack;
  logic       T1, T2, Tw1, Tw2, T3, T4;
  logic       fFetch, fMRead, fMWrite, fIORead, fIOWrite, fIntr;
  logic       nmi_taken;
  logic       int_taken;
  logic       busack;

  modport master (
    input  cyc_req, cyc_type, cyc_last, mwait, busrq, intr, nmi, iff1,
    output cyc_ack, T1, T2, Tw1, Tw2, T3, T4,
    output fFetch, fMRead, fMWrite, fIORead, fIOWrite, fIntr,
    output nmi_taken, int_taken, busack
  );

  modport slave (
    output cyc_req, cyc_type, cyc_last, mwait, busrq, intr, nmi, iff1,
    input  cyc_ack, T1, T2, Tw1, Tw2, T3, T4,
    input  fFetch, fMRead, fMWrite, fIORead, fIOWrite, fIntr,
    input  nmi_taken, int_taken, busack
  );
endinterface

// File: rtl/bus_cycle_sequencer.sv
// T-state / machine-cycle sequencer: walks T1..T4 with WAIT insertion, bus release and
// NMI/INTR arbitration at instruction boundaries. All outputs come straight from flops.
module bus_cycle_sequencer #(
  parameter int INTR_AUTO_WAIT = 1
) (
  input  logic                  clk,
  input  logic                  nreset,
  bus_cycle_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_T1, S_T2, S_TW1, S_TW2, S_T3, S_T4, S_BREL
  } state_e;

  typedef enum logic [2:0] {
    F_FETCH, F_MREAD, F_MWRITE, F_IOREAD, F_IOWRITE, F_INTR
  } func_e;

  localparam bit AUTO_WAIT = (INTR_AUTO_WAIT != 0);

  state_e     state_q, state_d;
  func_e      func_q, func_d;
  logic       nmi_latch_q, nmi_latch_d;
  logic       nmi_prev_q;
  logic       brel_boundary_q, brel_boundary_d;
  logic [5:0] t_q, t_d;
  logic [5:0] f_q, f_d;
  logic       cyc_ack_q, cyc_ack_d;
  logic       nmi_taken_q, nmi_taken_d;
  logic       int_taken_q, int_taken_d;
  logic       busack_q, busack_d;

  logic decide;
  logic boundary;
  logic nmi_clear;
  logic is_io;
  logic is_mem;
  logic is_intr;
  func_e req_func;

  always_comb begin
    state_d         = state_q;
    func_d          = func_q;
    brel_boundary_d = brel_boundary_q;
    cyc_ack_d       = 1'b0;
    nmi_taken_d     = 1'b0;
    int_taken_d     = 1'b0;
    decide          = 1'b0;
    boundary        = 1'b0;
    nmi_clear       = 1'b0;
    is_io           = (func_q == F_IOREAD) || (func_q == F_IOWRITE);
    is_mem          = (func_q == F_MREAD) || (func_q == F_MWRITE);
    is_intr         = (func_q == F_INTR);

    case (bus.cyc_type)
      3'd0:    req_func = F_FETCH;
      3'd2:    req_func = F_MWRITE;
      3'd3:    req_func = F_IOREAD;
      3'd4:    req_func = F_IOWRITE;
      default: req_func = F_MREAD;
    endcase

    case (state_q)
      S_IDLE: decide = 1'b1;
      // Bus release defers the boundary decision, so the boundary seen on entry is replayed here.
      S_BREL: begin
        decide   = 1'b1;
        boundary = brel_boundary_q;
      end
      S_T1: state_d = S_T2;
      S_T2: begin
        if (bus.mwait && !is_io && !(is_intr && AUTO_WAIT)) state_d = S_T2;
        else if (is_intr && AUTO_WAIT)                      state_d = S_TW1;
        else                                                state_d = S_T3;
      end
      S_TW1: state_d = S_TW2;
      S_TW2: state_d = bus.mwait ? S_TW2 : S_T3;
      S_T3: begin
        if (is_mem) begin
          decide   = 1'b1;
          boundary = bus.cyc_last;
        end else if (is_io && bus.mwait) begin
          state_d = S_T3;
        end else begin
          state_d = S_T4;
        end
      end
      S_T4: begin
        decide   = 1'b1;
        boundary = bus.cyc_last;
      end
      default: state_d = S_IDLE;
    endcase

    if (decide) begin
      if (bus.busrq) begin
        state_d         = S_BREL;
        brel_boundary_d = boundary;
      end else if (boundary && nmi_latch_q) begin
        state_d     = S_T1;
        func_d      = F_FETCH;
        nmi_taken_d = 1'b1;
        nmi_clear   = 1'b1;
      end else if (boundary && bus.intr && bus.iff1) begin
        state_d     = S_T1;
        func_d      = F_INTR;
        int_taken_d = 1'b1;
      end else if (bus.cyc_req) begin
        state_d   = S_T1;
        func_d    = req_func;
        cyc_ack_d = 1'b1;
      end else begin
        state_d = S_IDLE;
      end
    end

    // A fresh NMI edge in the clearing clock must survive, so set dominates clear.
    nmi_latch_d = (bus.nmi & ~nmi_prev_q) | (nmi_latch_q & ~nmi_clear);

    case (state_d)
      S_T1:    t_d = 6'b100000;
      S_T2:    t_d = 6'b010000;
      S_TW1:   t_d = 6'b001000;
      S_TW2:   t_d = 6'b000100;
      S_T3:    t_d = 6'b000010;
      S_T4:    t_d = 6'b000001;
      default: t_d = 6'b000000;
    endcase

    if (state_d == S_IDLE || state_d == S_BREL) begin
      f_d = 6'b000000;
    end else begin
      case (func_d)
        F_FETCH:   f_d = 6'b100000;
        F_MREAD:   f_d = 6'b010000;
        F_MWRITE:  f_d = 6'b001000;
        F_IOREAD:  f_d = 6'b000100;
        F_IOWRITE: f_d = 6'b000010;
        F_INTR:    f_d = 6'b000001;
        default:   f_d = 6'b000000;
      endcase
    end

    busack_d = (state_d == S_BREL);
  end

  always_ff @(posedge clk) begin
    if (!nreset) begin
      state_q         <= S_IDLE;
      func_q          <= F_FETCH;
      nmi_latch_q     <= 1'b0;
      nmi_prev_q      <= 1'b0;
      brel_boundary_q <= 1'b0;
      t_q             <= 6'b000000;
      f_q             <= 6'b000000;
      cyc_ack_q       <= 1'b0;
      nmi_taken_q     <= 1'b0;
      int_taken_q     <= 1'b0;
      busack_q        <= 1'b0;
    end else begin
      state_q         <= state_d;
      func_q          <= func_d;
      nmi_latch_q     <= nmi_latch_d;
      nmi_prev_q      <= bus.nmi;
      brel_boundary_q <= brel_boundary_d;
      t_q             <= t_d;
      f_q             <= f_d;
      cyc_ack_q       <= cyc_ack_d;
      nmi_taken_q     <= nmi_taken_d;
      int_taken_q     <= int_taken_d;
      busack_q        <= busack_d;
    end
  end

  assign bus.T1        = t_q[5];
  assign bus.T2        = t_q[4];
  assign bus.Tw1       = t_q[3];
  assign bus.Tw2       = t_q[2];
  assign bus.T3        = t_q[1];
  assign bus.T4        = t_q[0];
  assign bus.fFetch    = f_q[5];
  assign bus.fMRead    = f_q[4];
  assign bus.fMWrite   = f_q[3];
  assign bus.fIORead   = f_q[2];
  assign bus.fIOWrite  = f_q[1];
  assign bus.fIntr     = f_q[0];
  assign bus.cyc_ack   = cyc_ack_q;
  assign bus.nmi_taken = nmi_taken_q;
  assign bus.int_taken = int_taken_q;
  assign bus.busack    = busack_q;

endmodule
